// File: rtl/spi_rx_pkg.sv
// spi_rx_pkg: shared constants and helpers for the SPI receive packer.
//   - default word/pixel widths and the pack factor they imply
//   - bit-order constants for the MSB_FIRST parameter
//   - pack_n()  : data words per pixel for a given configuration
//   - cfg_ok()  : legality check for a parameter set
package spi_rx_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int PIX_W_DEF     = 16;
  localparam int PACK_N        = PIX_W_DEF / DATA_W_DEF;

  localparam int DATA_W_MIN    = 4;
  localparam int DATA_W_MAX    = 16;
  localparam int PACK_N_MAX    = 4;
  localparam int CMD_WORDS_MAX = 3;

  localparam bit MSB_FIRST_C   = 1'b1;
  localparam bit LSB_FIRST_C   = 1'b0;

  function automatic int pack_n(input int pix_w, input int data_w);
    return pix_w / data_w;
  endfunction

  function automatic bit cfg_ok(input int data_w, input int pix_w,
                                input int cmd_words, input bit msb_first);
    bit ok;
    ok = (data_w >= DATA_W_MIN) && (data_w <= DATA_W_MAX);
    ok = ok && (pix_w % data_w == 0);
    ok = ok && (pix_w / data_w >= 1) && (pix_w / data_w <= PACK_N_MAX);
    ok = ok && (cmd_words >= 0) && (cmd_words <= CMD_WORDS_MAX);
    ok = ok && ((msb_first == MSB_FIRST_C) || (msb_first == LSB_FIRST_C));
    return ok;
  endfunction

endpackage

// File: rtl/spi_rx_packer_shifter.sv
// spi_word_shifter: MOSI deserialiser for one SPI word.
//   i_spi_clk   : SPI clock, MOSI sampled on rising edge
//   i_rst_n     : async active-low reset
//   i_spi_cs    : active-low chip select; high clears the bit counter asynchronously
//   i_spi_mosi  : serial data
//   o_word_nxt  : word as it will be after the current edge (includes MOSI now)
//   o_last      : current edge samples the final bit of a word
module spi_word_shifter
  import spi_rx_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter bit MSB_FIRST = MSB_FIRST_C
) (
  input  logic              i_spi_clk,
  input  logic              i_rst_n,
  input  logic              i_spi_cs,
  input  logic              i_spi_mosi,
  output logic [DATA_W-1:0] o_word_nxt,
  output logic              o_last
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] r_sh;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] w_sh_nxt;

  // First-arrived bit ends at the MSB (MSB-first) or the LSB (LSB-first).
  if (MSB_FIRST == MSB_FIRST_C) begin : g_msb
    assign w_sh_nxt = {r_sh[DATA_W-2:0], i_spi_mosi};
  end else begin : g_lsb
    assign w_sh_nxt = {i_spi_mosi, r_sh[DATA_W-1:1]};
  end

  assign o_word_nxt = w_sh_nxt;
  assign o_last     = (r_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge i_spi_clk or negedge i_rst_n or posedge i_spi_cs) begin
    if (!i_rst_n) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_spi_cs) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else begin
      r_sh  <= w_sh_nxt;
      r_cnt <= o_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_rx_packer.sv
// spi_rx_packer: SPI-slave receiver that classifies words as command/data
// and packs data words into pixels, all in the i_spi_clk domain.
//   i_spi_clk/i_rst_n      : SPI clock, async active-low reset
//   i_spi_cs               : active-low CS; high clears frame state asynchronously
//   i_spi_mosi, i_dc       : serial data, data/command pin (USE_DC_PIN=1 only)
//   o_word, o_word_dc      : last word and its class (1 = data)
//   o_word_valid/o_word_tgl: per-word pulse / toggle
//   o_cmd                  : last command word
//   o_pix, o_pix_valid/tgl : packed pixel, per-pixel pulse / toggle
//   o_frame_words          : words in current frame, saturating
// Toggles are cleared only by reset so a 2-FF synchroniser in another domain
// never loses an edge across a CS rise.
module spi_rx_packer
  import spi_rx_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PIX_W      = PIX_W_DEF,
  parameter bit USE_DC_PIN = 1'b0,
  parameter int CMD_WORDS  = 1,
  parameter bit MSB_FIRST  = MSB_FIRST_C
) (
  input  logic              i_spi_clk,
  input  logic              i_rst_n,
  input  logic              i_spi_cs,
  input  logic              i_spi_mosi,
  input  logic              i_dc,
  output logic [DATA_W-1:0] o_word,
  output logic              o_word_dc,
  output logic              o_word_valid,
  output logic              o_word_tgl,
  output logic [DATA_W-1:0] o_cmd,
  output logic [PIX_W-1:0]  o_pix,
  output logic              o_pix_valid,
  output logic              o_pix_tgl,
  output logic [15:0]       o_frame_words
);

  localparam int PACK_N = pack_n(PIX_W, DATA_W);

  if (!cfg_ok(DATA_W, PIX_W, CMD_WORDS, MSB_FIRST)) begin : g_bad_cfg
    $error("spi_rx_packer: illegal DATA_W/PIX_W/CMD_WORDS combination");
  end

  logic [DATA_W-1:0] w_word_nxt;
  logic              w_last;
  logic              w_pos_dc;
  logic              w_dc;
  logic              w_pix_done;
  logic [PIX_W-1:0]  w_pix_nxt;

  logic [DATA_W-1:0] r_word;
  logic              r_word_dc;
  logic              r_word_vld;
  logic              r_word_tgl;
  logic [DATA_W-1:0] r_cmd;
  logic [PIX_W-1:0]  r_pix;
  logic              r_pix_vld;
  logic              r_pix_tgl;
  logic [15:0]       r_frame_words;
  logic [1:0]        r_phase;
  logic [PIX_W-1:0]  r_part;

  spi_word_shifter #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .i_spi_clk  (i_spi_clk),
    .i_rst_n    (i_rst_n),
    .i_spi_cs   (i_spi_cs),
    .i_spi_mosi (i_spi_mosi),
    .o_word_nxt (w_word_nxt),
    .o_last     (w_last)
  );

  // Position classification uses the count before this word is added.
  if (CMD_WORDS == 0) begin : g_all_data
    assign w_pos_dc = 1'b1;
  end else begin : g_pos_dc
    assign w_pos_dc = (r_frame_words >= 16'(CMD_WORDS));
  end

  assign w_dc       = USE_DC_PIN ? i_dc : w_pos_dc;
  assign w_pix_done = w_dc && (r_phase == 2'(PACK_N - 1));

  // Slot 0 is the MS word of the pixel.
  always_comb begin
    w_pix_nxt = r_part;
    for (int s = 0; s < PACK_N; s++) begin
      if (r_phase == 2'(s)) begin
        w_pix_nxt[(PACK_N-1-s)*DATA_W +: DATA_W] = w_word_nxt;
      end
    end
  end

  // Frame-scoped state: cleared by reset and by CS high.
  always_ff @(posedge i_spi_clk or negedge i_rst_n or posedge i_spi_cs) begin
    if (!i_rst_n) begin
      r_word_vld    <= 1'b0;
      r_pix_vld     <= 1'b0;
      r_frame_words <= '0;
      r_phase       <= '0;
      r_part        <= '0;
    end else if (i_spi_cs) begin
      r_word_vld    <= 1'b0;
      r_pix_vld     <= 1'b0;
      r_frame_words <= '0;
      r_phase       <= '0;
      r_part        <= '0;
    end else begin
      r_word_vld <= w_last;
      r_pix_vld  <= w_last && w_pix_done;
      if (w_last) begin
        if (r_frame_words != 16'hFFFF) r_frame_words <= r_frame_words + 16'd1;
        if (w_dc && !w_pix_done) begin
          r_phase <= r_phase + 2'd1;
          r_part  <= w_pix_nxt;
        end else begin
          // pixel finished, or a command discards the partial pixel
          r_phase <= '0;
          r_part  <= '0;
        end
      end
    end
  end

  // Held outputs and toggles: survive CS so the other domain sees every edge.
  always_ff @(posedge i_spi_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word     <= '0;
      r_word_dc  <= 1'b0;
      r_word_tgl <= 1'b0;
      r_cmd      <= '0;
      r_pix      <= '0;
      r_pix_tgl  <= 1'b0;
    end else if (!i_spi_cs && w_last) begin
      r_word     <= w_word_nxt;
      r_word_dc  <= w_dc;
      r_word_tgl <= ~r_word_tgl;
      if (!w_dc) begin
        r_cmd <= w_word_nxt;
      end else if (w_pix_done) begin
        r_pix     <= w_pix_nxt;
        r_pix_tgl <= ~r_pix_tgl;
      end
    end
  end

  assign o_word        = r_word;
  assign o_word_dc     = r_word_dc;
  assign o_word_valid  = r_word_vld;
  assign o_word_tgl    = r_word_tgl;
  assign o_cmd         = r_cmd;
  assign o_pix         = r_pix;
  assign o_pix_valid   = r_pix_vld;
  assign o_pix_tgl     = r_pix_tgl;
  assign o_frame_words = r_frame_words;

endmodule
